// File: rtl/frame_uploader_nbuf.sv
// Camera FIFO to SDRAM frame uploader: packs pixels into fixed-length write bursts over NUM_BUFFERS buffers.
// Optional macro FRAME_UPLOADER_PARTIAL_FLUSH_EN writes out (masked) partial bursts cut short by an early SOF.
module frame_uploader_nbuf #(
  parameter int PIXEL_WIDTH    = 16,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 21,
  parameter int BURST_WORDS    = 8,
  parameter int ADDR_INC       = 8,
  parameter int FRAME_WORDS    = 153600,
  parameter int NUM_BUFFERS    = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 21'h000000,
  parameter logic [ADDR_WIDTH-1:0] BUF_STRIDE = 21'h04B000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        init_done,
  input  logic [1:0]                  read_buffer,
  output logic                        queue_rd_en,
  input  logic                        queue_empty,
  input  logic [PIXEL_WIDTH:0]        queue_data,
  output logic                        cmd,
  output logic                        cmd_en,
  output logic [ADDR_WIDTH-1:0]       addr,
  output logic [MEM_DATA_WIDTH-1:0]   wr_data,
  output logic [MEM_DATA_WIDTH/8-1:0] data_mask,
  output logic                        frame_done,
  output logic [1:0]                  last_buffer,
  output logic                        frame_dropped
);

  localparam int PPW     = MEM_DATA_WIDTH / PIXEL_WIDTH;
  localparam int TOTAL   = BURST_WORDS * PPW;
  localparam int PCW     = $clog2(TOTAL + 1);
  localparam int WCW     = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam int LCW     = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int NBURSTS = FRAME_WORDS / BURST_WORDS;
  localparam int BCW     = $clog2(NBURSTS + 1);
  localparam int MW      = MEM_DATA_WIDTH / 8;

  localparam logic [PCW:0]   TOTAL_LVL  = (PCW+1)'(TOTAL);
  localparam logic [PCW-1:0] LAST_PIX   = PCW'(TOTAL - 1);
  localparam logic [LCW-1:0] LAST_LANE  = LCW'(PPW - 1);
  localparam logic [WCW-1:0] LAST_WORD  = WCW'(BURST_WORDS - 1);
  localparam logic [BCW-1:0] LAST_BURST = BCW'(NBURSTS - 1);
  localparam logic [1:0]     LAST_BUF   = 2'(NUM_BUFFERS - 1);

  typedef enum logic [2:0] {IDLE, WAIT_SOF, FILL, WRITE, DONE} state_t;

  state_t                            state;
  logic [1:0]                        buf_idx;
  logic [BCW-1:0]                    burst_idx;
  logic [PCW-1:0]                    pix_cnt;
  logic [LCW-1:0]                    lane_cnt;
  logic [WCW-1:0]                    fill_word;
  logic [WCW-1:0]                    wr_cnt;
  logic                              pending;
  logic [PPW-1:0][PIXEL_WIDTH-1:0]   word_buf [BURST_WORDS];
  logic [PCW:0]                      fill_level;
  logic                              is_sof;
  logic                              is_pixel;
  logic [ADDR_WIDTH-1:0]             burst_addr;
`ifdef FRAME_UPLOADER_PARTIAL_FLUSH_EN
  logic                              flushing;
`endif

  // Skips the locked buffer; with two buffers and one locked this lands back on i.
  function automatic logic [1:0] next_buf(input logic [1:0] i, input logic [1:0] locked);
    logic [1:0] n;
    n = (i >= LAST_BUF) ? 2'd0 : i + 2'd1;
    if (n == locked) n = (n >= LAST_BUF) ? 2'd0 : n + 2'd1;
    return n;
  endfunction

  assign is_sof     = pending && queue_data[PIXEL_WIDTH];
  assign is_pixel   = pending && !queue_data[PIXEL_WIDTH];
  assign fill_level = {1'b0, pix_cnt} + {{PCW{1'b0}}, pending};

  // Reads in flight are counted so the last accepted entry exactly fills the burst.
  always_comb begin
    queue_rd_en = 1'b0;
    case (state)
      WAIT_SOF: queue_rd_en = init_done && !queue_empty;
      FILL: begin
        queue_rd_en = init_done && !queue_empty && (fill_level < TOTAL_LVL);
`ifdef FRAME_UPLOADER_PARTIAL_FLUSH_EN
        if (is_sof) queue_rd_en = 1'b0;
`endif
      end
      default: queue_rd_en = 1'b0;
    endcase
  end

  always_comb begin
    burst_addr = BASE_ADDR + ADDR_WIDTH'(buf_idx) * BUF_STRIDE
               + ADDR_WIDTH'(burst_idx) * ADDR_WIDTH'(ADDR_INC);
    cmd_en     = (state == WRITE) && (wr_cnt == '0);
    cmd        = cmd_en;
    addr       = (state == WRITE) ? burst_addr : '0;
    wr_data    = (state == WRITE) ? word_buf[wr_cnt] : '0;
    frame_done = (state == DONE);
    data_mask  = '0;
`ifdef FRAME_UPLOADER_PARTIAL_FLUSH_EN
    if (state == WRITE) begin
      for (int b = 0; b < MW; b++) begin
        if (int'(wr_cnt) * PPW + (b * 8) / PIXEL_WIDTH >= int'(pix_cnt)) data_mask[b] = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      buf_idx       <= 2'd0;
      burst_idx     <= '0;
      pix_cnt       <= '0;
      lane_cnt      <= '0;
      fill_word     <= '0;
      wr_cnt        <= '0;
      pending       <= 1'b0;
      frame_dropped <= 1'b0;
      last_buffer   <= LAST_BUF;
`ifdef FRAME_UPLOADER_PARTIAL_FLUSH_EN
      flushing      <= 1'b0;
`endif
    end else begin
      pending       <= queue_rd_en;
      frame_dropped <= 1'b0;
      case (state)
        IDLE: begin
          if (init_done) state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (!init_done) begin
            state <= IDLE;
          end else if (is_sof) begin
            pix_cnt   <= '0;
            lane_cnt  <= '0;
            fill_word <= '0;
            burst_idx <= '0;
            state     <= FILL;
          end
        end
        FILL: begin
          if (!init_done) begin
            pix_cnt   <= '0;
            lane_cnt  <= '0;
            fill_word <= '0;
            burst_idx <= '0;
            state     <= IDLE;
          end else if (is_sof) begin
            frame_dropped <= 1'b1;
            burst_idx     <= '0;
`ifdef FRAME_UPLOADER_PARTIAL_FLUSH_EN
            // Partial burst stays in place; pix_cnt drives the byte mask during the flush.
            if (pix_cnt != '0) begin
              burst_idx <= burst_idx;
              flushing  <= 1'b1;
              wr_cnt    <= '0;
              state     <= WRITE;
            end
`else
            pix_cnt   <= '0;
            lane_cnt  <= '0;
            fill_word <= '0;
`endif
          end else if (is_pixel) begin
            word_buf[fill_word][lane_cnt] <= queue_data[PIXEL_WIDTH-1:0];
            pix_cnt <= pix_cnt + PCW'(1);
            if (lane_cnt == LAST_LANE) begin
              lane_cnt  <= '0;
              fill_word <= fill_word + WCW'(1);
            end else begin
              lane_cnt <= lane_cnt + LCW'(1);
            end
            if (pix_cnt == LAST_PIX) begin
              wr_cnt <= '0;
              state  <= WRITE;
            end
          end
        end
        WRITE: begin
          wr_cnt <= wr_cnt + WCW'(1);
          if (wr_cnt == LAST_WORD) begin
            pix_cnt   <= '0;
            lane_cnt  <= '0;
            fill_word <= '0;
`ifdef FRAME_UPLOADER_PARTIAL_FLUSH_EN
            if (flushing) begin
              flushing  <= 1'b0;
              burst_idx <= '0;
              state     <= init_done ? FILL : IDLE;
            end else
`endif
            if (burst_idx == LAST_BURST) begin
              burst_idx <= '0;
              state     <= DONE;
            end else begin
              burst_idx <= init_done ? burst_idx + BCW'(1) : '0;
              state     <= init_done ? FILL : IDLE;
            end
          end
        end
        DONE: begin
          last_buffer <= buf_idx;
          buf_idx     <= next_buf(buf_idx, read_buffer);
          burst_idx   <= '0;
          state       <= init_done ? WAIT_SOF : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_uploader_nbuf.sv
// Directed bench for frame_uploader_nbuf: table of whole-frame vectors plus reset/init corner sequences.
// Builds in either configuration of FRAME_UPLOADER_PARTIAL_FLUSH_EN.
module tb_frame_uploader_nbuf;

  logic        clk;
  logic        rst_n;
  logic        init_done;
  logic [1:0]  read_buffer;
  logic        queue_rd_en;
  logic        queue_empty;
  logic [16:0] queue_data;
  logic        cmd;
  logic        cmd_en;
  logic [20:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  data_mask;
  logic        frame_done;
  logic [1:0]  last_buffer;
  logic        frame_dropped;

  frame_uploader_nbuf #(
    .PIXEL_WIDTH(16), .MEM_DATA_WIDTH(32), .ADDR_WIDTH(21), .BURST_WORDS(8),
    .ADDR_INC(8), .FRAME_WORDS(16), .NUM_BUFFERS(3),
    .BASE_ADDR(21'h000000), .BUF_STRIDE(21'h000100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .read_buffer(read_buffer),
    .queue_rd_en(queue_rd_en), .queue_empty(queue_empty), .queue_data(queue_data),
    .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .wr_data(wr_data), .data_mask(data_mask),
    .frame_done(frame_done), .last_buffer(last_buffer), .frame_dropped(frame_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          frag;
    bit          gap;
    logic [20:0] addr0;
    logic [20:0] addr1;
    logic [1:0]  last;
    int          drops;
  } vec_t;

  vec_t        vecs[4];
  logic [16:0] fifo_q[$];
  logic [20:0] burst_addr_q[$];
  int          burst_base_q[$];
  logic [31:0] word_q[$];
  logic [3:0]  mask_q[$];
  logic [15:0] pix[32];
  logic [15:0] frag_pix[5];
  logic [20:0] cur_addr;
  int          cap_left = 0;
  int          done_cnt = 0;
  int          drop_cnt = 0;
  int          drop_at_cmd = 0;
  int          extra_cmd = 0;
  int          addr_moved = 0;
  int          bad_cmd = 0;
  int          checks = 0;
  int          passed = 0;

  // FIFO model: pushes happen on negedges, pops on posedges with one-cycle read latency.
  initial begin
    queue_empty = 1'b1;
    queue_data  = '0;
  end
  always @(posedge clk) begin
    if (queue_rd_en && !queue_empty) begin
      queue_data  <= fifo_q.pop_front();
      queue_empty <= (fifo_q.size() == 0);
    end
  end

  // Burst monitor: records each burst's address and its BURST_WORDS data/mask beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      cap_left = 0;
    end else begin
      if (frame_done) done_cnt++;
      if (frame_dropped) begin
        drop_cnt++;
        if (cmd_en) drop_at_cmd++;
      end
      if (cap_left > 0) begin
        word_q.push_back(wr_data);
        mask_q.push_back(data_mask);
        if (cmd_en) extra_cmd++;
        if (addr != cur_addr) addr_moved++;
        cap_left--;
      end else if (cmd_en) begin
        cur_addr = addr;
        burst_addr_q.push_back(addr);
        burst_base_q.push_back(word_q.size());
        word_q.push_back(wr_data);
        mask_q.push_back(data_mask);
        if (!cmd) bad_cmd++;
        cap_left = 7;
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_entry(input logic [16:0] v);
    fifo_q.push_back(v);
    queue_empty = 1'b0;
  endtask

  task automatic apply_stimulus(input int frag, input bit gap);
    push_entry(17'h10000);
    if (frag > 0) begin
      for (int k = 0; k < frag; k++) begin
        frag_pix[k] = 16'($urandom);
        push_entry({1'b0, frag_pix[k]});
      end
      push_entry(17'h10000);
    end
    for (int k = 0; k < 32; k++) begin
      pix[k] = 16'($urandom);
      push_entry({1'b0, pix[k]});
      if (gap && k == 10) repeat (30) @(negedge clk);
    end
  endtask

  task automatic wait_frame_done(output bit got);
    got = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (frame_done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_burst(input int idx, input logic [20:0] exp_addr, input int half, input string tag);
    int base;
    base = burst_base_q[idx];
    check_output($sformatf("%s addr", tag), burst_addr_q[idx], exp_addr);
    for (int w = 0; w < 8; w++) begin
      check_output($sformatf("%s word%0d", tag, w), word_q[base + w],
                   {pix[half*16 + 2*w + 1], pix[half*16 + 2*w]});
      check_output($sformatf("%s mask%0d", tag, w), mask_q[base + w], 4'h0);
    end
  endtask

  task automatic check_flush_burst(input int idx, input logic [20:0] exp_addr);
    int base;
    logic [3:0] exp_mask;
    base = burst_base_q[idx];
    check_output("flush addr", burst_addr_q[idx], exp_addr);
    check_output("flush word0", word_q[base], {frag_pix[1], frag_pix[0]});
    check_output("flush word1", word_q[base + 1], {frag_pix[3], frag_pix[2]});
    check_output("flush word2 low", word_q[base + 2][15:0], frag_pix[4]);
    for (int w = 0; w < 8; w++) begin
      exp_mask = (w < 2) ? 4'h0 : (w == 2) ? 4'b1100 : 4'hF;
      check_output($sformatf("flush mask%0d", w), mask_q[base + w], exp_mask);
    end
  endtask

  initial begin
    int  b0, drop0, dac0, flush_b, busy, nb;
    bit  got;

    vecs[0] = '{frag: 0, gap: 1'b0, addr0: 21'h000000, addr1: 21'h000008, last: 2'd0, drops: 0};
    vecs[1] = '{frag: 0, gap: 1'b1, addr0: 21'h000100, addr1: 21'h000108, last: 2'd1, drops: 0};
    vecs[2] = '{frag: 0, gap: 1'b0, addr0: 21'h000000, addr1: 21'h000008, last: 2'd0, drops: 0};
    vecs[3] = '{frag: 5, gap: 1'b0, addr0: 21'h000100, addr1: 21'h000108, last: 2'd1, drops: 1};

    rst_n       = 1'b0;
    init_done   = 1'b0;
    read_buffer = 2'd2;
    repeat (3) @(negedge clk);
    check_output("reset outputs", {queue_rd_en, cmd, cmd_en, addr, wr_data, data_mask, frame_done, frame_dropped}, '0);
    check_output("reset last_buffer", last_buffer, 2'd2);
    rst_n = 1'b1;

    // Memory not ready: queued entries must sit untouched.
    for (int k = 0; k < 3; k++) push_entry({1'b0, 16'($urandom)});
    busy = 0;
    repeat (100) begin
      @(negedge clk);
      if (queue_rd_en || cmd_en) busy++;
    end
    check_output("idle rd/cmd cycles", busy, 0);
    check_output("idle fifo level", fifo_q.size(), 3);
    init_done = 1'b1;

    for (int i = 0; i < 4; i++) begin
      b0    = burst_addr_q.size();
      drop0 = drop_cnt;
      dac0  = drop_at_cmd;
      apply_stimulus(vecs[i].frag, vecs[i].gap);
      wait_frame_done(got);
      check_output($sformatf("frame%0d done seen", i), got, 1'b1);
      @(negedge clk);
      check_output($sformatf("frame%0d last_buffer", i), last_buffer, vecs[i].last);
      flush_b = 0;
`ifdef FRAME_UPLOADER_PARTIAL_FLUSH_EN
      if (vecs[i].frag > 0) flush_b = 1;
`endif
      nb = burst_addr_q.size() - b0;
      check_output($sformatf("frame%0d bursts", i), nb, 2 + flush_b);
      if (nb == 2 + flush_b) begin
        if (flush_b == 1) check_flush_burst(b0, vecs[i].addr0);
        check_burst(b0 + flush_b, vecs[i].addr0, 0, $sformatf("f%0d b0", i));
        check_burst(b0 + flush_b + 1, vecs[i].addr1, 1, $sformatf("f%0d b1", i));
      end
      check_output($sformatf("frame%0d drops", i), drop_cnt - drop0, vecs[i].drops);
      if (flush_b == 1) check_output("drop on cmd_en", drop_at_cmd - dac0, 1);
    end

    // Reset lands on the third data beat of a burst.
    apply_stimulus(0, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (cmd_en) begin
        got = 1'b1;
        break;
      end
    end
    check_output("pre-reset burst seen", got, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("mid-burst reset outputs", {queue_rd_en, cmd, cmd_en, addr, wr_data, data_mask, frame_done, frame_dropped}, '0);
    check_output("mid-burst reset last_buffer", last_buffer, 2'd2);
    @(negedge clk);
    rst_n = 1'b1;
    busy = 0;
    repeat (60) begin
      @(negedge clk);
      if (cmd_en) busy++;
    end
    check_output("no reissued cmd_en", busy, 0);
    b0 = burst_addr_q.size();
    apply_stimulus(0, 1'b0);
    wait_frame_done(got);
    check_output("post-reset done seen", got, 1'b1);
    @(negedge clk);
    nb = burst_addr_q.size() - b0;
    check_output("post-reset bursts", nb, 2);
    if (nb == 2) begin
      check_burst(b0, 21'h000000, 0, "rst b0");
      check_burst(b0 + 1, 21'h000008, 1, "rst b1");
    end
    check_output("post-reset last_buffer", last_buffer, 2'd0);

    check_output("cmd_en beyond word0", extra_cmd, 0);
    check_output("addr moved in burst", addr_moved, 0);
    check_output("cmd low on cmd_en", bad_cmd, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/frame_uploader_nbuf.md
Name: frame_uploader_nbuf

Overview:
Parametrised successor to the camera-to-SDRAM frame uploader.
- Drains the camera FIFO: (PIXEL_WIDTH+1)-bit entries, MSB = start-of-frame (SOF) marker.
- Packs pixels into MEM_DATA_WIDTH words and issues fixed-length write bursts to the SDRAM controller.
- Rotates over NUM_BUFFERS frame buffers and never writes the buffer the display reader has locked.
- Sits between FIFO_cam and the memory controller inside VideoController.

Parameters:
PIXEL_WIDTH, 16, pixel bits per FIFO entry (excluding marker bit)
MEM_DATA_WIDTH, 32, memory word width; integer multiple of PIXEL_WIDTH
ADDR_WIDTH, 21, memory address width
BURST_WORDS, 8, memory words per write burst (power of 2)
ADDR_INC, 8, address increment per burst
FRAME_WORDS, 153600, memory words per frame; multiple of BURST_WORDS
NUM_BUFFERS, 2, frame buffer count, 2..4
BASE_ADDR, 21'h000000, address of buffer 0
BUF_STRIDE, 21'h04B000, address distance between buffers

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
init_done  in  1  memory controller ready; no FIFO reads or commands while low
read_buffer  in  2  buffer index locked by display reader
queue_rd_en  out  1  FIFO read enable
queue_empty  in  1  FIFO empty
queue_data  in  PIXEL_WIDTH+1  FIFO data; valid the cycle after rd_en with !empty
cmd  out  1  1 = write
cmd_en  out  1  command strobe, one cycle per burst
addr  out  ADDR_WIDTH  burst start address
wr_data  out  MEM_DATA_WIDTH  write data
data_mask  out  MEM_DATA_WIDTH/8  byte mask, 1 = masked
frame_done  out  1  one-cycle pulse when a full frame is written
last_buffer  out  2  index of most recently completed buffer
frame_dropped  out  1  one-cycle pulse on SOF before frame completion

Behaviour:
Reset values (rst_n low at a clk edge):
- All outputs 0; state IDLE; write buffer index 0.
- last_buffer = NUM_BUFFERS-1.

States:
- IDLE: go to WAIT_SOF when init_done=1.
- WAIT_SOF:
  - queue_rd_en = !queue_empty.
  - Non-marker entries are discarded.
  - A marker entry clears the pack/burst counters and enters FILL.
- FILL:
  - queue_rd_en = !queue_empty while the burst buffer is not full.
  - Pixels pack LSB-first: the first pixel goes in wr_data[PIXEL_WIDTH-1:0].
  - After BURST_WORDS words are stored, go to WRITE.
  - Reads are stopped so that no FIFO entry arrives after the buffer is full (account for the 1-cycle read latency).
- WRITE:
  - cmd_en=1 and cmd=1 for exactly the first cycle.
  - addr = BASE_ADDR + buf_idx*BUF_STRIDE + burst_idx*ADDR_INC, stable for the whole burst.
  - wr_data presents words 0..BURST_WORDS-1 on consecutive cycles; word 0 coincides with cmd_en. data_mask=0.
  - After the last word, burst_idx increments.
  - If burst_idx*BURST_WORDS reaches FRAME_WORDS, go to DONE; otherwise go to FILL.
  - queue_rd_en=0 throughout WRITE.
- DONE, one cycle:
  - frame_done=1; last_buffer <= buf_idx.
  - buf_idx <= next(buf_idx), then go to WAIT_SOF.

next(i):
- n = (i+1) mod NUM_BUFFERS.
- If n == read_buffer, use n = (n+1) mod NUM_BUFFERS.
- If that equals i, stay on i.
- read_buffer is sampled in DONE only.

Boundary conditions:
- SOF during FILL:
  - Partial burst is discarded; burst_idx clears; frame_dropped pulses.
  - buf_idx and last_buffer are unchanged; re-enter FILL for the new frame.
- SOF inside a packed word also discards the partial pixels of that word.
- queue_empty mid-burst: FILL waits with no timeout.
- init_done dropping: finish any burst in progress, then return to IDLE. Pack and burst progress are discarded; the next SOF restarts the frame.
- rst_n low mid-burst: outputs go to reset values on that edge, and cmd_en is not re-issued.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

Optional Feature:
FRAME_UPLOADER_PARTIAL_FLUSH_EN
- Defined: on SOF during FILL, the partially filled burst is written in WRITE before restarting the frame.
  - Unfilled words and unfilled pixel lanes carry data_mask=1 for their bytes.
  - frame_dropped still pulses, on the cmd_en cycle.
- Undefined: the partial burst is discarded as above, and data_mask is constant 0.

Test Plan:
Bench parameters: FRAME_WORDS=16, BURST_WORDS=8, ADDR_INC=8, NUM_BUFFERS=3, BUF_STRIDE=21'h000100, read_buffer=2.

1. init_done=0 with entries queued -> queue_rd_en and cmd_en stay 0 for 100 cycles.
2. SOF, 32 random pixels, SOF:
   - Burst 1: cmd_en with addr 0x000000; words {p1,p0}..{p15,p14}, cmd_en only on word 0.
   - Burst 2 at addr 0x000008.
   - Then frame_done pulses and last_buffer=0.
3. Second full frame -> bursts at 0x000100 and 0x000108; last_buffer=1.
4. Third frame -> buffer 2 is locked, so bursts go to 0x000000 and 0x000008; last_buffer=0.
5. SOF, 5 pixels, SOF, 32 pixels -> no command from the first fragment; frame_dropped pulses once; the following frame is written at the unchanged buffer's base.
   - With FRAME_UPLOADER_PARTIAL_FLUSH_EN: one burst instead, words 0-1 full, word 2 with lower half valid (mask 4'b1100), words 3-7 mask 4'hF.
6. Reset asserted on the 3rd data word of a burst -> all outputs 0 the next cycle; after re-init, the first burst goes to 0x000000.
